// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions.
//   WORD_W    : datapath / instruction width
//   NOP_INSTR : bubble word placed in pipeline registers
//   if_id_t   : IF/ID pipeline record, also consumed by the decode stage
package arm_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'hE000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc_plus1;
        logic [WORD_W-1:0] instruction;
        logic              valid;
    } if_id_t;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction memory read bus between the fetch stage and the memory.
//   imem_address     : word address, driven by the fetch stage
//   imem_instruction : instruction word returned in the same cycle
// master = fetch stage, slave = instruction memory.
interface instruction_fetch_stage_if;
    import arm_pkg::*;

    logic [WORD_W-1:0] imem_address;
    logic [WORD_W-1:0] imem_instruction;

    modport master (output imem_address, input imem_instruction);
    modport slave  (input imem_address, output imem_instruction);

endinterface

// File: rtl/pc_register.sv
// Program counter register.
//   clk, rst_n : clock, async active-low reset (pc clears to 0)
//   load_en    : update pc on the next rising edge
//   sel_target : next value is the masked target instead of pc+1
//   target     : branch destination word address
//   pc         : current pc, zero-extended
//   pc_plus1   : (pc+1) mod DEPTH, zero-extended
module pc_register
    import arm_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              sel_target,
    input  logic [WORD_W-1:0] target,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus1
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_next;

    // Explicit wrap keeps the increment correct even for non-power-of-two depths.
    assign pc_inc  = (pc_q == AW'(DEPTH - 1)) ? '0 : pc_q + AW'(1);
    assign pc_next = sel_target ? target[AW-1:0] : pc_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else if (load_en) begin
            pc_q <= pc_next;
        end
    end

    assign pc       = WORD_W'(pc_q);
    assign pc_plus1 = WORD_W'(pc_inc);

    // Upper target bits fall outside the memory and are intentionally dropped.
    generate
        if (AW < WORD_W) begin : g_target_hi
            logic unused_target_hi;
            assign unused_target_hi = ^target[WORD_W-1:AW];
        end
    endgenerate

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, reads instruction memory and
// registers the result into IF/ID.
//   clk, rst_n      : clock, async active-low reset
//   imem            : instruction memory bus (master side)
//   stall, flush    : hold / bubble controls
//   branch_taken    : redirect pc to branch_target (overrides stall/flush)
//   pc              : current fetch address
//   if_pc, if_instruction, if_valid : IF/ID register contents
//   fetch_count     : instructions accepted into IF/ID since reset
module instruction_fetch_stage
    import arm_pkg::*;
#(
    parameter int                DEPTH     = 1024,
    parameter logic [WORD_W-1:0] NOP_INSTR = arm_pkg::NOP_INSTR
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instruction_fetch_stage_if.master imem,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      branch_taken,
    input  logic [WORD_W-1:0]         branch_target,
    output logic [WORD_W-1:0]         pc,
    output logic [WORD_W-1:0]         if_pc,
    output logic [WORD_W-1:0]         if_instruction,
    output logic                      if_valid,
    output logic [WORD_W-1:0]         fetch_count
);

    localparam if_id_t BUBBLE = '{pc_plus1: '0, instruction: NOP_INSTR, valid: 1'b0};

    logic [WORD_W-1:0] pc_plus1;
    logic              pc_load;
    if_id_t            if_id_q;
    if_id_t            if_id_d;
    logic              fetch_en;

    // A branch always moves the pc; otherwise only a stall freezes it.
    assign pc_load = branch_taken || !stall;

    pc_register #(.DEPTH(DEPTH)) u_pc_register (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (pc_load),
        .sel_target (branch_taken),
        .target     (branch_target),
        .pc         (pc),
        .pc_plus1   (pc_plus1)
    );

    assign imem.imem_address = pc;

    always_comb begin
        if_id_d  = if_id_q;
        fetch_en = 1'b0;
        if (branch_taken) begin
            if_id_d = BUBBLE;
        end else if (stall) begin
            if (flush) begin
                if_id_d = BUBBLE;
            end
        end else if (flush) begin
            if_id_d = BUBBLE;
        end else begin
            if_id_d  = '{pc_plus1: pc_plus1, instruction: imem.imem_instruction, valid: 1'b1};
            fetch_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_q     <= BUBBLE;
            fetch_count <= '0;
        end else begin
            if_id_q <= if_id_d;
            if (fetch_en) begin
                fetch_count <= fetch_count + WORD_W'(1);
            end
        end
    end

    assign if_pc          = if_id_q.pc_plus1;
    assign if_instruction = if_id_q.instruction;
    assign if_valid       = if_id_q.valid;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'hE000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] pc, if_pc, if_instruction, fetch_count;
    logic        if_valid;

    logic [31:0] mem [0:DEPTH-1];

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    int unsigned m_pc, m_if_pc, m_count;
    logic [31:0] m_instr;
    logic        m_valid;

    instruction_fetch_stage_if ifc();

    instruction_fetch_stage #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (ifc),
        .stall          (stall),
        .flush          (flush),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .pc             (pc),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .if_valid       (if_valid),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    always_comb ifc.imem_instruction = mem[ifc.imem_address[9:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_if_pc = 0; m_count = 0; m_instr = NOP; m_valid = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    pc, m_pc);
        chk({tag, ".addr"},  ifc.imem_address, m_pc);
        chk({tag, ".if_pc"}, if_pc, m_if_pc);
        chk({tag, ".instr"}, if_instruction, m_instr);
        chk({tag, ".valid"}, {31'b0, if_valid}, {31'b0, m_valid});
        chk({tag, ".count"}, fetch_count, m_count);
    endtask

    // Drive controls, take one rising edge, advance the model, compare.
    task automatic cycle(input logic b, input logic [31:0] bt, input logic st, input logic fl,
                         input string tag);
        branch_taken = b; branch_target = bt; stall = st; flush = fl;
        @(posedge clk);
        #1;
        if (b) begin
            m_pc = bt % DEPTH;
            m_if_pc = 0; m_instr = NOP; m_valid = 1'b0;
        end else if (st && fl) begin
            m_if_pc = 0; m_instr = NOP; m_valid = 1'b0;
        end else if (st) begin
            // everything holds
        end else if (fl) begin
            m_pc = (m_pc + 1) % DEPTH;
            m_if_pc = 0; m_instr = NOP; m_valid = 1'b0;
        end else begin
            m_instr = mem[m_pc];
            m_pc = (m_pc + 1) % DEPTH;
            m_if_pc = m_pc;
            m_valid = 1'b1;
            m_count = m_count + 1;
        end
        branch_taken = 1'b0; stall = 1'b0; flush = 1'b0;
        check_all(tag);
    endtask

    int unsigned saved_count;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);

        // reset values
        model_reset();
        #12;
        check_all("reset");
        chk("reset_instr_nop", if_instruction, NOP);
        #1 rst_n = 1'b1;

        // free-running from address 0
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b0, '0, 1'b0, 1'b0, "free");
            chk("seq_instr", if_instruction, 32'(k - 1));
            chk("seq_if_pc", if_pc, 32'(k));
            chk("seq_valid", {31'b0, if_valid}, 32'd1);
        end
        chk("seq_count", fetch_count, 32'd5);

        // stall held at pc = 7
        cycle(1'b0, '0, 1'b0, 1'b0, "free");
        cycle(1'b0, '0, 1'b0, 1'b0, "free");
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, "stall");
            chk("stall_pc", pc, 32'd7);
            chk("stall_count", fetch_count, 32'd7);
            chk("stall_instr", if_instruction, 32'd6);
        end
        cycle(1'b0, '0, 1'b0, 1'b0, "unstall");
        chk("unstall_instr", if_instruction, 32'd7);
        chk("unstall_pc", pc, 32'd8);

        // branch overrides stall and flush
        cycle(1'b1, 32'd100, 1'b1, 1'b1, "branch");
        chk("br_pc", pc, 32'd100);
        chk("br_valid", {31'b0, if_valid}, 32'd0);
        chk("br_instr", if_instruction, NOP);
        cycle(1'b0, '0, 1'b0, 1'b0, "br_next");
        chk("br_tgt_instr", if_instruction, 32'd100);
        chk("br_tgt_if_pc", if_pc, 32'd101);

        // flush alone at pc = 4
        cycle(1'b1, 32'd4, 1'b0, 1'b0, "br4");
        saved_count = fetch_count;
        cycle(1'b0, '0, 1'b0, 1'b1, "flush");
        chk("flush_pc", pc, 32'd5);
        chk("flush_valid", {31'b0, if_valid}, 32'd0);
        chk("flush_count", fetch_count, saved_count);
        cycle(1'b0, '0, 1'b0, 1'b0, "post_flush");
        chk("post_flush_instr", if_instruction, 32'd5);

        // wrap-around and target masking
        cycle(1'b1, 32'd1023, 1'b0, 1'b0, "br_last");
        cycle(1'b0, '0, 1'b0, 1'b0, "wrap");
        chk("wrap_if_pc", if_pc, 32'd0);
        chk("wrap_pc", pc, 32'd0);
        chk("wrap_instr", if_instruction, 32'd1023);
        cycle(1'b1, 32'd1030, 1'b0, 1'b0, "br_mask");
        chk("mask_pc", pc, 32'd6);

        // a control pulse between edges must be ignored
        branch_taken = 1'b1; branch_target = 32'd300; stall = 1'b1; flush = 1'b1;
        #3;
        branch_taken = 1'b0; stall = 1'b0; flush = 1'b0;
        cycle(1'b0, '0, 1'b0, 1'b0, "glitch");
        chk("glitch_pc", pc, 32'd7);

        // asynchronous reset mid-cycle at pc = 42
        cycle(1'b1, 32'd42, 1'b0, 1'b0, "br42");
        chk("pre_rst_pc", pc, 32'd42);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #2 rst_n = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b0, "after_rst");
        chk("after_rst_pc", pc, 32'd1);
        chk("after_rst_instr", if_instruction, 32'd0);

        // randomized traffic against the model with random memory contents
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rand_rst");
        #1 rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic b, st, fl;
            b  = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 6) == 0);
            cycle(b, $urandom, st, fl, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Instruction fetch (IF) stage of the ARM pipeline. It is the reader side of the word-indexed instruction memory. It owns the program counter and drives the memory address combinationally from it. It registers each returned instruction into the IF/ID pipeline register, and handles stall, flush, branch redirect and a retired-fetch counter.

## Interface
Parameters:
- DEPTH, 1024: instruction memory depth in words; the PC wraps modulo DEPTH.
- NOP_INSTR, 32'hE000_0000: bubble word loaded into IF/ID on reset, flush or branch.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_address  output  32  word address to the instruction memory; equals pc.
- imem_instruction  input  32  instruction word from memory, valid in the same cycle as imem_address.
- stall  input  1  hold the PC and IF/ID contents.
- flush  input  1  replace IF/ID contents with a bubble.
- branch_taken  input  1  redirect the PC to branch_target.
- branch_target  input  32  word address of the branch destination.
- pc  output  32  current fetch address.
- if_pc  output  32  registered pc+1 of the instruction held in IF/ID.
- if_instruction  output  32  registered instruction word.
- if_valid  output  1  IF/ID holds a real instruction, not a bubble.
- fetch_count  output  32  number of instructions accepted into IF/ID since reset.

## Operation
- Memory is word-indexed, so the PC counts words:
  - next sequential PC = (pc+1) mod DEPTH;
  - a taken branch target is reduced to its low log2(DEPTH) bits and zero-extended.
- Per-cycle priority, highest first:
  1. branch_taken: pc <= target; IF/ID <= {0, NOP_INSTR, valid 0}; fetch_count holds. This applies regardless of stall and flush.
  2. stall && flush: pc holds; IF/ID <= bubble; fetch_count holds.
  3. stall: pc, IF/ID and fetch_count all hold.
  4. flush: pc <= pc+1 (mod DEPTH); IF/ID <= bubble; fetch_count holds. The instruction fetched this cycle is discarded.
  5. otherwise: pc <= pc+1 (mod DEPTH); IF/ID <= {pc+1 (mod DEPTH), imem_instruction, 1}; fetch_count <= fetch_count+1.
- fetch_count wraps from 32'hFFFF_FFFF to 0.
- if_pc carries the wrapped sequential value, so it is 0 when pc = DEPTH-1.
- imem_address is pc zero-extended to 32 bits. It has no registered delay.

## Timing
- Reset values while rst_n is low (asynchronous, no clock needed):
  - pc = 0
  - imem_address = 0
  - if_pc = 0
  - if_instruction = NOP_INSTR
  - if_valid = 0
  - fetch_count = 0
- First rising edge after reset release with no control asserted: IF/ID = {1, mem[0], 1} and pc = 1.
- Fetch latency: one cycle from pc presentation to the instruction appearing on if_instruction.
- Branch penalty: the edge that samples branch_taken loads the target. The following cycle shows a bubble, and the target instruction appears in IF/ID one edge later.
- Control inputs are sampled only on rising edges. Glitches between edges have no effect.
- Reset asserted mid-operation forces all outputs to their reset values immediately, independent of clk. Any in-flight fetch is lost.

## Structure
- Shared package arm_pkg holds:
  - WORD_W = 32;
  - NOP_INSTR = 32'hE000_0000;
  - the IF/ID record typedef {pc_plus1, instruction, valid}, reused by the decode stage.
- One sub-module, pc_register. It holds the PC with async active-low reset, load-enable and next-value input. It performs the modulo-DEPTH increment and target masking.
- The IF/ID register, priority logic and fetch counter live in instruction_fetch_stage.

## Test plan
- Reset then 5 free-running cycles with memory word n = n:
  - if_instruction sequence is 0,1,2,3,4;
  - if_pc sequence is 1..5;
  - fetch_count = 5;
  - if_valid is 1 from edge 1 onward.
- Stall held 3 cycles at pc = 7: pc stays 7, and IF/ID and fetch_count are unchanged. After release, the next edge yields if_instruction = mem[7] and pc = 8.
- branch_taken with target 100, asserted together with stall and flush:
  - next edge: pc = 100, if_valid = 0, if_instruction = NOP_INSTR;
  - following edge: if_instruction = mem[100], if_pc = 101.
- Flush alone at pc = 4: pc becomes 5, if_valid = 0 and fetch_count is unchanged. The next edge loads mem[5].
- Wrap-around: branch to DEPTH-1 = 1023, then one free cycle gives if_pc = 0 and pc = 0. A branch to 1030 lands at pc = 6.
- Asynchronous reset asserted mid-cycle at pc = 42: all outputs reach their reset values before the next clock edge. After release, fetch resumes at address 0.
